// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word sizes, IV, ME state encodings, controller states.
package sha256_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_WORDS  = 8;
    localparam int unsigned HASH_W     = WORD_W * NUM_WORDS;
    localparam int unsigned BLK_W      = 512;
    localparam int unsigned ROUND_W    = 7;
    localparam int unsigned KIDX_W     = 6;
    localparam int unsigned NUM_ROUNDS = 64;

    // Index of the final compression round, at the ME round-counter width.
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    // Initial hash value H0..H7, H0 in the top word.
    localparam logic [HASH_W-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Message expander FSM encodings as reported on i_me_state.
    typedef enum logic [1:0] {
        ME_IDLE   = 2'b00,
        ME_R0_15  = 2'b01,
        ME_R16_63 = 2'b10,
        ME_R64    = 2'b11
    } me_state_e;

    // Block controller states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_UPDATE = 3'd3,
        S_DRAIN  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/sha256_h_update.sv
// Feed-forward adder: eight independent modulo-2^32 sums H_i + working variable i.
module sha256_h_update
    import sha256_pkg::*;
#(
    parameter int unsigned WORD_W_P = WORD_W
) (
    input  logic [NUM_WORDS*WORD_W_P-1:0] i_hash,
    input  logic [NUM_WORDS*WORD_W_P-1:0] i_state,
    output logic [NUM_WORDS*WORD_W_P-1:0] o_sum
);

    // One adder per word; carries never cross word boundaries.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        assign o_sum[gi*WORD_W_P +: WORD_W_P] =
            i_hash[gi*WORD_W_P +: WORD_W_P] + i_state[gi*WORD_W_P +: WORD_W_P];
    end

endmodule

// File: rtl/sha256_block_sched.sv
// SHA-256 block controller: accepts blocks, sequences ME/compression, owns H0..H7.
module sha256_block_sched
    import sha256_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_blk_valid,
    output logic                 o_blk_ready,
    input  logic                 i_blk_first,
    input  logic                 i_blk_last,
    input  logic [BLK_W-1:0]     i_blk_data,
    output logic                 o_me_load,
    output logic [BLK_W-1:0]     o_me_words,
    input  logic [ROUND_W-1:0]   i_me_round,
    input  logic [1:0]           i_me_state,
    output logic                 o_comp_init,
    output logic                 o_comp_en,
    output logic [KIDX_W-1:0]    o_round,
    input  logic [HASH_W-1:0]    i_comp_state,
    output logic [HASH_W-1:0]    o_hash,
    output logic [HASH_W-1:0]    o_digest,
    output logic                 o_digest_valid,
    output logic                 o_busy
);

    ctrl_state_e         r_state;
    ctrl_state_e         w_next_state;
    logic                r_last;
    logic [HASH_W-1:0]   r_hash;
    logic [HASH_W-1:0]   r_digest;
    logic [BLK_W-1:0]    r_me_words;
    logic                r_me_load;
    logic                r_comp_init;
    logic                r_digest_valid;
    logic                r_busy;
    logic                w_accept;
    logic                w_blk_ready;
    logic                w_comp_en;
    logic                w_me_idle;
    logic                w_me_running;
    logic [HASH_W-1:0]   w_sum;

    assign w_me_idle    = (i_me_state == ME_IDLE);
    assign w_me_running = (i_me_state == ME_R0_15) || (i_me_state == ME_R16_63);

    sha256_h_update #(
        .WORD_W_P (DATA_WIDTH)
    ) u_h_update (
        .i_hash  (r_hash),
        .i_state (i_comp_state),
        .o_sum   (w_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the handshake and round-enable strobes.
    always_comb begin
        w_next_state = r_state;
        w_blk_ready  = 1'b0;
        w_accept     = 1'b0;
        w_comp_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_blk_ready = w_me_idle;
                if (i_blk_valid && w_me_idle) begin
                    w_accept     = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = S_RUN;
            end
            S_RUN: begin
                // Any ME state other than a round phase is out of sequence: abandon the block.
                if (w_me_running) begin
                    w_comp_en = 1'b1;
                    if (i_me_round == LAST_ROUND) begin
                        w_next_state = S_UPDATE;
                    end
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            S_UPDATE: begin
                w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_me_idle) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Block capture, chaining-hash update, digest and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hash         <= IV;
            r_digest       <= '0;
            r_me_words     <= '0;
            r_last         <= 1'b0;
            r_me_load      <= 1'b0;
            r_comp_init    <= 1'b0;
            r_digest_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_me_load      <= w_accept;
            r_comp_init    <= w_accept;
            r_digest_valid <= 1'b0;
            r_busy         <= (w_next_state != S_IDLE);
            if (w_accept) begin
                r_me_words <= i_blk_data;
                r_last     <= i_blk_last;
                if (i_blk_first) begin
                    r_hash <= IV;
                end
            end
            if (r_state == S_UPDATE) begin
                r_hash <= w_sum;
                if (r_last) begin
                    r_digest       <= w_sum;
                    r_digest_valid <= 1'b1;
                end
            end
        end
    end

    assign o_blk_ready    = w_blk_ready;
    assign o_comp_en      = w_comp_en;
    assign o_round        = i_me_round[KIDX_W-1:0];
    assign o_me_load      = r_me_load;
    assign o_comp_init    = r_comp_init;
    assign o_me_words     = r_me_words;
    assign o_hash         = r_hash;
    assign o_digest       = r_digest;
    assign o_digest_valid = r_digest_valid;
    assign o_busy         = r_busy;

endmodule
